// File: rtl/dpram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dpram_arb_pkg
// Shared definitions for the page-table dpram arbiter:
//   NUM_REQ_DEF  default requester count
//   PTR_W        round-robin pointer width for the default requester count
//   ID_W         width of the requester id held in a grant tag (covers 8)
//   grant_tag_t  per-port tag registered at grant time: {vld, rd, id}
// -----------------------------------------------------------------------------
package dpram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int PTR_W       = $clog2(NUM_REQ_DEF);
    localparam int ID_W        = 3;

    // vld: the port was granted; rd: the granted access was a read;
    // id: which requester owns the response.
    typedef struct packed {
        logic            vld;
        logic            rd;
        logic [ID_W-1:0] id;
    } grant_tag_t;

endpackage

// File: rtl/dpram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpram_arbiter_if
// Requester-side bus of the dpram arbiter.
//   req_valid/req_ready/req_wen  one bit per requester
//   req_addr/req_wdata           packed, requester i at [i*W +: W]
//   rsp_valid/rsp_port           one bit per requester
//   rsp_rdata/rsp_rdata_b        shared read buses for port A / port B
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dpram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wen;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_port;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [DATA_WIDTH-1:0]         rsp_rdata_b;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_port, rsp_rdata, rsp_rdata_b
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_port, rsp_rdata, rsp_rdata_b
    );
endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin picker: finds the first set bit of req at or after index start,
// wrapping around. Implemented as rotate-by-start, find-first-one, unrotate.
//   req    in   NUM_REQ  candidate vector
//   start  in   PW       search start index (must be < NUM_REQ)
//   found  out  1        some candidate present
//   idx    out  PW       index of the chosen candidate (valid when found)
// -----------------------------------------------------------------------------
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PW      = PTR_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      start,
    output logic               found,
    output logic [PW-1:0]      idx
);
    logic [NUM_REQ-1:0] rot;
    logic [PW-1:0]      first_k;

    // rot[k] is the requester k positions after start
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [PW-1:0] src;
        assign src     = PW'((int'(start) + gi) % NUM_REQ);
        assign rot[gi] = req[src];
    end

    // Descending scan so the lowest rotated position wins
    always_comb begin
        found   = 1'b0;
        first_k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found   = 1'b1;
                first_k = PW'(i);
            end
        end
    end

    assign idx = PW'((int'(start) + int'(first_k)) % NUM_REQ);

endmodule

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
// Shares both ports of one dpram between NUM_REQ requesters (MMU table-walk and
// update clients). Up to two grants per cycle, one per RAM port, round-robin.
//   clk, rst_n                  clock, asynchronous active-low reset
//   bus (slave)                 requester handshake and read responses
//   wen_a/addr_a/data_a, q_a    dpram port A
//   wen_b/addr_b/data_b, q_b    dpram port B
// Reads return one cycle after the grant on rsp_rdata (port A) or rsp_rdata_b
// (port B), selected per requester by rsp_port. Writes complete at handshake.
// -----------------------------------------------------------------------------
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpram_arbiter_if.slave        bus,
    output logic                  wen_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] q_a,
    output logic                  wen_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic [DATA_WIDTH-1:0] q_b
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         ptr_reg, ptr_next;
    grant_tag_t            tag_a_reg, tag_a_next;
    grant_tag_t            tag_b_reg, tag_b_next;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic                  a_found, b_found;
    logic [PW-1:0]         a_idx, b_idx;
    logic [PW-1:0]         a_succ, b_succ;
    logic [NUM_REQ-1:0]    a_onehot;
    logic [NUM_REQ-1:0]    b_cand;
    logic                  hazard;
    logic                  grant_a, grant_b;
    logic [NUM_REQ-1:0]    ready_vec;
    logic [NUM_REQ-1:0]    rsp_valid_vec;
    logic [NUM_REQ-1:0]    rsp_port_vec;

    // Unpack per-requester address/data
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign a_onehot[gi]  = a_found && (a_idx == PW'(gi));
    end

    assign a_succ = PW'((int'(a_idx) + 1) % NUM_REQ);
    assign b_succ = PW'((int'(b_idx) + 1) % NUM_REQ);

    // Port A: first valid at or after ptr
    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick_a (
        .req   (bus.req_valid),
        .start (ptr_reg),
        .found (a_found),
        .idx   (a_idx)
    );

    // Port B: next valid after the A grantee, A grantee excluded
    assign b_cand = bus.req_valid & ~a_onehot;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick_b (
        .req   (b_cand),
        .start (a_succ),
        .found (b_found),
        .idx   (b_idx)
    );

    // A write on either port to the shared address makes the port order
    // observable, so B backs off and retries; read/read is harmless.
    assign hazard = a_found && b_found &&
                    (addr_arr[a_idx] == addr_arr[b_idx]) &&
                    (bus.req_wen[a_idx] || bus.req_wen[b_idx]);

    // rst_n gating keeps grants and RAM writes quiet while held in reset
    assign grant_a = a_found && rst_n;
    assign grant_b = b_found && !hazard && rst_n;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign ready_vec[gi] = (grant_a && (a_idx == PW'(gi))) ||
                               (grant_b && (b_idx == PW'(gi)));
    end
    assign bus.req_ready = ready_vec;

    // RAM port drive; ungranted ports are held at zero
    assign wen_a  = grant_a && bus.req_wen[a_idx];
    assign addr_a = grant_a ? addr_arr[a_idx]  : '0;
    assign data_a = grant_a ? wdata_arr[a_idx] : '0;
    assign wen_b  = grant_b && bus.req_wen[b_idx];
    assign addr_b = grant_b ? addr_arr[b_idx]  : '0;
    assign data_b = grant_b ? wdata_arr[b_idx] : '0;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_b) begin
            ptr_next = b_succ;
        end else if (grant_a) begin
            ptr_next = a_succ;
        end
    end

    always_comb begin
        tag_a_next     = '0;
        tag_a_next.vld = grant_a;
        tag_a_next.rd  = grant_a && !bus.req_wen[a_idx];
        tag_a_next.id  = ID_W'(a_idx);
        tag_b_next     = '0;
        tag_b_next.vld = grant_b;
        tag_b_next.rd  = grant_b && !bus.req_wen[b_idx];
        tag_b_next.id  = ID_W'(b_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            tag_a_reg <= '0;
            tag_b_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            tag_a_reg <= tag_a_next;
            tag_b_reg <= tag_b_next;
        end
    end

    // Response routing from the tags registered at grant time
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
        logic hit_a, hit_b;
        assign hit_a = tag_a_reg.vld && tag_a_reg.rd && (tag_a_reg.id == ID_W'(gi));
        assign hit_b = tag_b_reg.vld && tag_b_reg.rd && (tag_b_reg.id == ID_W'(gi));
        assign rsp_valid_vec[gi] = hit_a || hit_b;
        assign rsp_port_vec[gi]  = hit_b;
    end

    assign bus.rsp_valid   = rsp_valid_vec;
    assign bus.rsp_port    = rsp_port_vec;
    assign bus.rsp_rdata   = q_a;
    assign bus.rsp_rdata_b = q_b;

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
// Directed bench for dpram_arbiter with a behavioural dual-port RAM
// (registered read, old data on read-during-write).
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          wen_a, wen_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] q_a, q_b;
    logic [DW-1:0] mem [64];

    int tests_run = 0;
    int failed    = 0;

    dpram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .wen_a  (wen_a),
        .addr_a (addr_a),
        .data_a (data_a),
        .q_a    (q_a),
        .wen_b  (wen_b),
        .addr_b (addr_b),
        .data_b (data_b),
        .q_b    (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen_a) mem[addr_a] <= data_a;
        if (wen_b) mem[addr_b] <= data_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_wen[i]           = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(16 + i), DW'(i));
        #1;
        $display("[TB] reset held: valid=%b ready=%b wen_a=%b wen_b=%b", bus.req_valid, bus.req_ready, wen_a, wen_b);
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            failed++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
        end
        tests_run++;
        if (wen_a !== 1'b0 || wen_b !== 1'b0) begin
            failed++; $display("FAIL reset_wen: got a=%b b=%b expected 0 0", wen_a, wen_b);
        end
        tests_run++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_port !== 4'b0000) begin
            failed++; $display("FAIL reset_rsp: got valid=%b port=%b expected 0000 0000", bus.rsp_valid, bus.rsp_port);
        end
        bus.req_wen = '0;
        rst_n = 1'b1;
        #1;
        $display("[TB] reset released: ready=%b addr_a=%0d addr_b=%0d", bus.req_ready, addr_a, addr_b);
        tests_run++;
        if (bus.req_ready !== 4'b0011 || addr_a !== 6'd16 || addr_b !== 6'd17) begin
            failed++; $display("FAIL first_grant: got ready=%b addr_a=%0d addr_b=%0d expected 0011 16 17", bus.req_ready, addr_a, addr_b);
        end
        step();
        clear_reqs();
        #1;
        tests_run++;
        if (bus.rsp_valid !== 4'b0011 || bus.rsp_port !== 4'b0010) begin
            failed++; $display("FAIL first_rsp: got valid=%b port=%b expected 0011 0010", bus.rsp_valid, bus.rsp_port);
        end
    endtask

    // ptr is 2 on entry
    task automatic test_read_latency();
        set_req(2, 1'b1, 1'b1, 6'd5, 64'hAA);
        #1;
        $display("[TB] write req2 addr5: ready=%b wen_a=%b addr_a=%0d", bus.req_ready, wen_a, addr_a);
        tests_run++;
        if (bus.req_ready !== 4'b0100 || wen_a !== 1'b1 || addr_a !== 6'd5 || data_a !== 64'hAA) begin
            failed++; $display("FAIL write_grant: got ready=%b wen_a=%b addr_a=%0d data_a=%h expected 0100 1 5 aa", bus.req_ready, wen_a, addr_a, data_a);
        end
        step();
        set_req(2, 1'b1, 1'b0, 6'd5, 64'h0);
        #1;
        $display("[TB] read req2 addr5: ready=%b wen_a=%b", bus.req_ready, wen_a);
        tests_run++;
        if (bus.req_ready !== 4'b0100 || wen_a !== 1'b0 || addr_a !== 6'd5) begin
            failed++; $display("FAIL read_grant: got ready=%b wen_a=%b addr_a=%0d expected 0100 0 5", bus.req_ready, wen_a, addr_a);
        end
        step();
        clear_reqs();
        #1;
        $display("[TB] read rsp: rsp_valid=%b port=%b rdata=%h", bus.rsp_valid, bus.rsp_port, bus.rsp_rdata);
        tests_run++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_port !== 4'b0000 || bus.rsp_rdata !== 64'hAA) begin
            failed++; $display("FAIL read_rsp: got valid=%b port=%b data=%h expected 0100 0000 aa", bus.rsp_valid, bus.rsp_port, bus.rsp_rdata);
        end
        step();
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            failed++; $display("FAIL rsp_pulse: got valid=%b expected 0000", bus.rsp_valid);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        set_req(0, 1'b1, 1'b1, 6'd3, 64'h1234);
        set_req(1, 1'b1, 1'b0, 6'd3, 64'h0);
        #1;
        $display("[TB] hazard w0/r1 addr3: ready=%b wen_a=%b wen_b=%b", bus.req_ready, wen_a, wen_b);
        tests_run++;
        if (bus.req_ready !== 4'b0001 || wen_a !== 1'b1 || wen_b !== 1'b0 || addr_b !== 6'd0) begin
            failed++; $display("FAIL hazard_ready: got ready=%b wen_a=%b wen_b=%b addr_b=%0d expected 0001 1 0 0", bus.req_ready, wen_a, wen_b, addr_b);
        end
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, 64'h0);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0010 || addr_a !== 6'd3) begin
            failed++; $display("FAIL hazard_retry: got ready=%b addr_a=%0d expected 0010 3", bus.req_ready, addr_a);
        end
        step();
        clear_reqs();
        #1;
        $display("[TB] hazard retry rsp: valid=%b rdata=%h", bus.rsp_valid, bus.rsp_rdata);
        tests_run++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_port !== 4'b0000 || bus.rsp_rdata !== 64'h1234) begin
            failed++; $display("FAIL hazard_data: got valid=%b port=%b data=%h expected 0010 0000 1234", bus.rsp_valid, bus.rsp_port, bus.rsp_rdata);
        end
        // read/read to the same address is not a hazard
        do_reset();
        set_req(0, 1'b1, 1'b0, 6'd3, 64'h0);
        set_req(1, 1'b1, 1'b0, 6'd3, 64'h0);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0011) begin
            failed++; $display("FAIL rr_same_addr: got ready=%b expected 0011", bus.req_ready);
        end
        step();
        clear_reqs();
        #1;
        $display("[TB] r/r rsp: valid=%b port=%b a=%h b=%h", bus.rsp_valid, bus.rsp_port, bus.rsp_rdata, bus.rsp_rdata_b);
        tests_run++;
        if (bus.rsp_valid !== 4'b0011 || bus.rsp_port !== 4'b0010 ||
            bus.rsp_rdata !== 64'h1234 || bus.rsp_rdata_b !== 64'h1234) begin
            failed++; $display("FAIL rr_rsp: got valid=%b port=%b a=%h b=%h expected 0011 0010 1234 1234", bus.rsp_valid, bus.rsp_port, bus.rsp_rdata, bus.rsp_rdata_b);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]    exp_rdy [4];
        logic [3:0]    exp_rsp [4];
        logic [AW-1:0] exp_a   [4];
        logic [AW-1:0] exp_b   [4];
        int            cnt     [NR];
        exp_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        exp_rsp = '{4'b0000, 4'b0011, 4'b1100, 4'b0011};
        exp_a   = '{6'd8, 6'd10, 6'd8, 6'd10};
        exp_b   = '{6'd9, 6'd11, 6'd9, 6'd11};
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(8 + i), 64'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            $display("[TB] fair cycle %0d: ready=%b rsp=%b addr_a=%0d addr_b=%0d", c, bus.req_ready, bus.rsp_valid, addr_a, addr_b);
            tests_run++;
            if (bus.req_ready !== exp_rdy[c] || bus.rsp_valid !== exp_rsp[c] ||
                addr_a !== exp_a[c] || addr_b !== exp_b[c]) begin
                failed++; $display("FAIL fair_c%0d: got ready=%b rsp=%b a=%0d b=%0d expected %b %b %0d %0d", c, bus.req_ready, bus.rsp_valid, addr_a, addr_b, exp_rdy[c], exp_rsp[c], exp_a[c], exp_b[c]);
            end
            for (int i = 0; i < NR; i++) cnt[i] += int'(bus.req_ready[i]);
            step();
        end
        clear_reqs();
        for (int i = 0; i < NR; i++) begin
            tests_run++;
            if (cnt[i] != 2) begin
                failed++; $display("FAIL fair_count_req%0d: got %0d grants expected 2", i, cnt[i]);
            end
        end
    endtask

    // ptr is 0 on entry
    task automatic test_wrap();
        set_req(2, 1'b1, 1'b0, 6'd20, 64'h0);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0100) begin
            failed++; $display("FAIL wrap_setup: got ready=%b expected 0100", bus.req_ready);
        end
        step();
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 6'd21, 64'h0);
        set_req(3, 1'b1, 1'b0, 6'd22, 64'h0);
        #1;
        $display("[TB] wrap ptr=3 valid=1001: ready=%b addr_a=%0d addr_b=%0d", bus.req_ready, addr_a, addr_b);
        tests_run++;
        if (bus.req_ready !== 4'b1001 || addr_a !== 6'd22 || addr_b !== 6'd21) begin
            failed++; $display("FAIL wrap_grant: got ready=%b a=%0d b=%0d expected 1001 22 21", bus.req_ready, addr_a, addr_b);
        end
        step();
        set_req(1, 1'b1, 1'b0, 6'd23, 64'h0);
        set_req(2, 1'b1, 1'b0, 6'd20, 64'h0);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0110 || addr_a !== 6'd23) begin
            failed++; $display("FAIL wrap_ptr: got ready=%b addr_a=%0d expected 0110 23", bus.req_ready, addr_a);
        end
        step();
        clear_reqs();
    endtask

    task automatic test_midop_reset();
        // reset asserted mid-way through the grant cycle
        do_reset();
        set_req(2, 1'b1, 1'b0, 6'd5, 64'h0);
        #3;
        rst_n = 1'b0;
        clear_reqs();
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0000 || wen_a !== 1'b0) begin
            failed++; $display("FAIL midop_ready: got ready=%b wen_a=%b expected 0000 0", bus.req_ready, wen_a);
        end
        step();
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            failed++; $display("FAIL midop_rsp_in_reset: got %b expected 0000", bus.rsp_valid);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            failed++; $display("FAIL midop_rsp_after: got %b expected 0000", bus.rsp_valid);
        end
        // reset asserted while the response pulse is pending
        set_req(2, 1'b1, 1'b0, 6'd5, 64'h0);
        step();
        clear_reqs();
        tests_run++;
        if (bus.rsp_valid !== 4'b0100) begin
            failed++; $display("FAIL midop_pending: got %b expected 0100", bus.rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset on pending rsp: rsp_valid=%b", bus.rsp_valid);
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            failed++; $display("FAIL midop_async_clear: got %b expected 0000", bus.rsp_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            failed++; $display("FAIL midop_no_spurious: got %b expected 0000", bus.rsp_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_read_latency();
        test_hazard();
        test_fairness();
        test_wrap();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
